led_fade_ramp: RTL and testbench

- Duty-cycle slew limiter between the register bank and a pwm instance; one instance per colour channel.
- Takes a target duty (e.g. pwm_cfg.pwm_red) and walks its output duty toward the target in programmable steps at a programmable rate.
- The output drives pwm.duty_cycle directly, so register writes produce smooth fades instead of hard jumps.

---
 rtl/led_fade_ramp_pkg.sv | 19 +
 rtl/led_fade_ramp_prescaler.sv | 31 +++
 rtl/led_fade_ramp.sv | 148 ++++++++++++++
 tb/tb_led_fade_ramp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_fade_ramp_pkg.sv
// Shared types and constants for the LED fade ramp.
// Duty width, prescaler width, FSM state encoding and the step-size helper.
package led_fade_ramp_pkg;

  localparam int FADE_DW = 8;
  localparam int FADE_PW = 16;

  typedef enum logic [1:0] {
    FADE_IDLE,
    FADE_UP,
    FADE_DOWN
  } fade_state_t;

  // A programmed step of zero still has to make progress, so it moves by one.
  function automatic logic [3:0] eff_step(input logic [3:0] step_size);
    return (step_size == 4'd0) ? 4'd1 : step_size;
  endfunction

endpackage

// File: rtl/led_fade_ramp_prescaler.sv
// Step-rate prescaler for the LED fade ramp.
// Counts while run is high and pulses tick once count reaches period. The
// compare is >= so that lowering period below the current count fires on
// the very next cycle instead of waiting for a full counter wrap.
module led_fade_ramp_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          run,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] count;

  assign tick = run && (count >= period);

  // Free-running step counter, cleared whenever the ramp is not running.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/led_fade_ramp.sv
// LED fade ramp: duty-cycle slew limiter between the register bank and a pwm.
// Walks duty_out toward target in steps of step_size every step_period+1
// clocks; busy is high while ramping and done pulses on arrival.
// Optional ping-pong breathing between 0 and target is compiled in only when
// the macro LED_FADE_BREATHE_EN is defined; otherwise breathe is ignored.
module led_fade_ramp
  import led_fade_ramp_pkg::*;
#(
  parameter int DW = FADE_DW,
  parameter int PW = FADE_PW
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          ena,
  input  logic [DW-1:0] target,
  input  logic [PW-1:0] step_period,
  input  logic [3:0]    step_size,
  input  logic          breathe,
  output logic [DW-1:0] duty_out,
  output logic          busy,
  output logic          done
);

  fade_state_t   state;
  fade_state_t   state_n;
  fade_state_t   dir;
  fade_state_t   bounce;
  logic [DW-1:0] duty_n;
  logic [DW-1:0] goal;
  logic [DW-1:0] stepped;
  logic          done_n;
  logic          run;
  logic          tick;
  logic [DW:0]   s_ext;
  logic [DW:0]   sum_up;
  logic [DW:0]   lim_dn;

  // The prescaler only runs while actively ramping; ena low or IDLE clears it.
  assign run = ena && (state != FADE_IDLE);

  led_fade_ramp_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk    (clk),
    .resetb (resetb),
    .run    (run),
    .period (step_period),
    .tick   (tick)
  );

`ifndef LED_FADE_BREATHE_EN
  // Breathing is compiled out; the port stays for a uniform channel interface.
  logic unused_breathe;
  assign unused_breathe = breathe;
`endif

  // Pick the goal for this cycle, the direction toward it, and the state to
  // enter on arrival (IDLE normally, the opposite slope when breathing).
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    goal   = target;
    bounce = FADE_IDLE;
    if (target > duty_out) begin
      dir = FADE_UP;
    end else if (target < duty_out) begin
      dir = FADE_DOWN;
    end else begin
      dir = FADE_IDLE;
    end
`ifdef LED_FADE_BREATHE_EN
    // Breathing with a zero target degenerates to a plain hold at 0.
    if (breathe && (target != '0)) begin
      if ((state == FADE_DOWN) || (target < duty_out)) begin
        goal   = '0;
        bounce = FADE_UP;
        dir    = (duty_out != '0) ? FADE_DOWN : FADE_IDLE;
      end else begin
        bounce = FADE_DOWN;
      end
    end
`endif
  end

  // Saturating step toward goal, computed one bit wider so it can neither
  // wrap past the ends of the duty range nor overshoot the goal.
  always_comb begin
    s_ext  = (DW+1)'(eff_step(step_size));
    sum_up = {1'b0, duty_out} + s_ext;
    lim_dn = {1'b0, goal} + s_ext;
    if (dir == FADE_UP) begin
      stepped = (sum_up >= {1'b0, goal}) ? goal : sum_up[DW-1:0];
    end else begin
      stepped = ({1'b0, duty_out} <= lim_dn) ? goal : (duty_out - s_ext[DW-1:0]);
    end
  end

  // Next-state, next-duty and arrival-pulse decode.
  always_comb begin
    state_n = state;
    duty_n  = duty_out;
    done_n  = 1'b0;
    if (!ena) begin
      state_n = FADE_IDLE;
    end else begin
      case (state)
        FADE_IDLE: begin
          // Already at target: stay put (or start the down slope when breathing).
          state_n = (dir == FADE_IDLE) ? bounce : dir;
        end
        FADE_UP, FADE_DOWN: begin
          if (dir == FADE_IDLE) begin
            // Target moved onto the current duty without a step.
            state_n = bounce;
            done_n  = 1'b1;
          end else begin
            state_n = dir;
            if (tick) begin
              duty_n = stepped;
              if (stepped == goal) begin
                state_n = bounce;
                done_n  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_n = FADE_IDLE;
        end
      endcase
    end
  end

  // State, duty and status registers; busy and done are registered outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state    <= FADE_IDLE;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      duty_out <= duty_n;
      busy     <= (state_n != FADE_IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_led_fade_ramp.sv
// Self-checking bench for led_fade_ramp.
// Directed vector table followed by hand-written corner sequences (reset
// mid-ramp, target landing on duty without a step, breathing when enabled).
module tb_led_fade_ramp;

  logic        clk = 1'b0;
  logic        resetb;
  logic        ena;
  logic [7:0]  target;
  logic [15:0] step_period;
  logic [3:0]  step_size;
  logic        breathe;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  led_fade_ramp dut (
    .clk         (clk),
    .resetb      (resetb),
    .ena         (ena),
    .target      (target),
    .step_period (step_period),
    .step_size   (step_size),
    .breathe     (breathe),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cycles;
    logic        ena;
    logic [7:0]  target;
    logic [15:0] sp;
    logic [3:0]  ss;
    logic [7:0]  duty;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int w, input logic e, input logic [7:0] t,
                              input logic [15:0] p, input logic [3:0] s,
                              input logic [7:0] d, input logic b, input logic dn);
    vec_t v;
    v.wait_cycles = w; v.ena = e; v.target = t; v.sp = p; v.ss = s;
    v.duty = d; v.busy = b; v.done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic b, input logic dn);
    check({tag, ".duty"}, 32'(duty_out), 32'(d));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    // Ramp 0 -> 0x80, step 1 every 4 clocks: duty k lands at edge 1+4k.
    vecs.push_back(mk(1,   1, 8'h80, 16'd3, 4'd1, 8'h00, 1, 0));
    vecs.push_back(mk(4,   1, 8'h80, 16'd3, 4'd1, 8'h01, 1, 0));
    vecs.push_back(mk(4,   1, 8'h80, 16'd3, 4'd1, 8'h02, 1, 0));
    vecs.push_back(mk(3,   1, 8'h80, 16'd3, 4'd1, 8'h02, 1, 0));
    vecs.push_back(mk(1,   1, 8'h80, 16'd3, 4'd1, 8'h03, 1, 0));
    vecs.push_back(mk(499, 1, 8'h80, 16'd3, 4'd1, 8'h7F, 1, 0));
    vecs.push_back(mk(1,   1, 8'h80, 16'd3, 4'd1, 8'h80, 0, 1));
    vecs.push_back(mk(1,   1, 8'h80, 16'd3, 4'd1, 8'h80, 0, 0));
    // 0x80 -> 0xFC by 4 each clock, then 0xFC -> 0xFF by 8 saturates.
    vecs.push_back(mk(1,   1, 8'hFC, 16'd0, 4'd4, 8'h80, 1, 0));
    vecs.push_back(mk(30,  1, 8'hFC, 16'd0, 4'd4, 8'hF8, 1, 0));
    vecs.push_back(mk(1,   1, 8'hFC, 16'd0, 4'd4, 8'hFC, 0, 1));
    vecs.push_back(mk(1,   1, 8'hFF, 16'd0, 4'd8, 8'hFC, 1, 0));
    vecs.push_back(mk(1,   1, 8'hFF, 16'd0, 4'd8, 8'hFF, 0, 1));
    vecs.push_back(mk(1,   1, 8'hFF, 16'd0, 4'd8, 8'hFF, 0, 0));
    vecs.push_back(mk(5,   1, 8'hFF, 16'd0, 4'd8, 8'hFF, 0, 0));
    // 0xFF -> 0x30 by 15: last step clamps 0x3C -> 0x30.
    vecs.push_back(mk(1,   1, 8'h30, 16'd0, 4'd15, 8'hFF, 1, 0));
    vecs.push_back(mk(13,  1, 8'h30, 16'd0, 4'd15, 8'h3C, 1, 0));
    vecs.push_back(mk(1,   1, 8'h30, 16'd0, 4'd15, 8'h30, 0, 1));
    // Up toward 0x80 with step_size 0 (moves by 1) every 2 clocks.
    vecs.push_back(mk(1,   1, 8'h80, 16'd1, 4'd0, 8'h30, 1, 0));
    vecs.push_back(mk(2,   1, 8'h80, 16'd1, 4'd0, 8'h31, 1, 0));
    vecs.push_back(mk(30,  1, 8'h80, 16'd1, 4'd0, 8'h40, 1, 0));
    // At 0x40 the target reverses to 0x10: flip to DOWN, no done.
    vecs.push_back(mk(1,   1, 8'h10, 16'd1, 4'd0, 8'h40, 1, 0));
    vecs.push_back(mk(1,   1, 8'h10, 16'd1, 4'd0, 8'h3F, 1, 0));
    vecs.push_back(mk(92,  1, 8'h10, 16'd1, 4'd0, 8'h11, 1, 0));
    vecs.push_back(mk(2,   1, 8'h10, 16'd1, 4'd0, 8'h10, 0, 1));
    // Up by 8 every 3 clocks; drop ena at 0x30 for 100 clocks, then resume.
    vecs.push_back(mk(1,   1, 8'h80, 16'd2, 4'd8, 8'h10, 1, 0));
    vecs.push_back(mk(11,  1, 8'h80, 16'd2, 4'd8, 8'h28, 1, 0));
    vecs.push_back(mk(1,   1, 8'h80, 16'd2, 4'd8, 8'h30, 1, 0));
    vecs.push_back(mk(1,   0, 8'h80, 16'd2, 4'd8, 8'h30, 0, 0));
    vecs.push_back(mk(99,  0, 8'h80, 16'd2, 4'd8, 8'h30, 0, 0));
    vecs.push_back(mk(1,   1, 8'h80, 16'd2, 4'd8, 8'h30, 1, 0));
    vecs.push_back(mk(2,   1, 8'h80, 16'd2, 4'd8, 8'h30, 1, 0));
    vecs.push_back(mk(1,   1, 8'h80, 16'd2, 4'd8, 8'h38, 1, 0));

    resetb = 1'b0; ena = 1'b0; target = '0; step_period = '0; step_size = '0; breathe = 1'b0;
    step(2);
    check_out("reset", 8'h00, 1'b0, 1'b0);
    resetb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ena         = vecs[i].ena;
      target      = vecs[i].target;
      step_period = vecs[i].sp;
      step_size   = vecs[i].ss;
      step(vecs[i].wait_cycles);
      check_out($sformatf("v%0d", i), vecs[i].duty, vecs[i].busy, vecs[i].done);
    end

    // Reset held for one clock in the middle of a ramp aborts it.
    step(1);
    resetb = 1'b0;
    step(1);
    check_out("rst_mid", 8'h00, 1'b0, 1'b0);

    // Target moved onto the current duty between steps: done, back to IDLE.
    resetb = 1'b1; target = 8'h08; step_period = 16'd0; step_size = 4'd1;
    step(6);
    check_out("eq_pre", 8'h05, 1'b1, 1'b0);
    target = 8'h05;
    step(1);
    check_out("eq_hit", 8'h05, 1'b0, 1'b1);
    step(1);
    check_out("eq_post", 8'h05, 1'b0, 1'b0);

    resetb = 1'b0;
    step(1);
    resetb = 1'b1;
`ifdef LED_FADE_BREATHE_EN
    // Triangle 0 -> 0x20 -> 0 with a 16-clock period, done at each endpoint.
    target = 8'h20; step_size = 4'd4; step_period = 16'd0; breathe = 1'b1;
    step(1);
    check_out("br_start", 8'h00, 1'b1, 1'b0);
    step(8);
    check_out("br_top1", 8'h20, 1'b1, 1'b1);
    step(1);
    check_out("br_fall", 8'h1C, 1'b1, 1'b0);
    step(7);
    check_out("br_bot1", 8'h00, 1'b1, 1'b1);
    step(8);
    check_out("br_top2", 8'h20, 1'b1, 1'b1);
    step(8);
    check_out("br_bot2", 8'h00, 1'b1, 1'b1);
    breathe = 1'b0;
    step(8);
    check_out("br_end", 8'h20, 1'b0, 1'b1);
    step(3);
    check_out("br_idle", 8'h20, 1'b0, 1'b0);
`else
    // breathe has no effect without the feature: plain ramp, then idle.
    target = 8'h04; step_size = 4'd4; step_period = 16'd0; breathe = 1'b1;
    step(1);
    check_out("nb_start", 8'h00, 1'b1, 1'b0);
    step(1);
    check_out("nb_hit", 8'h04, 1'b0, 1'b1);
    step(2);
    check_out("nb_idle", 8'h04, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
